universal_shift_reg_burst: RTL and testbench

//  Parametrised successor to the 4-bit universal shift register.
//  - Generalised width and an extended mode set: rotate, arithmetic shift, auto-shift burst.
//  - Burst mode shifts a loaded word by N positions, one per clock, with busy/done status.
//  - Sits between parallel datapath registers and bit-serial links (SPI-like shifters, CRC/LFSR feeders).

---
 rtl/universal_shift_reg_burst.sv | 87 ++++++++
 tb/tb_universal_shift_reg_burst.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg_burst.sv
// Parametrised universal shift register: hold/shift/load/rotate/arith-shift plus an
// auto-shift burst mode that walks a loaded word N positions with busy/done status.
module universal_shift_reg_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       sel,
   input  logic             serial_in,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic [CNT_W-1:0] count,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

   // Burst length never exceeds WIDTH: beyond that the word is already fully refilled.
   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
      if (c > MAX_CNT) return MAX_CNT;
      return c;
   endfunction

   logic [CNT_W-1:0]        rem;
   logic                    dir_lat;
   logic [WIDTH-1:0]        q_nxt;
   logic [CNT_W-1:0]        rem_nxt;
   logic                    dir_nxt;
   logic                    done_nxt;
   logic [CNT_W-1:0]        burst_cnt;
   logic signed [WIDTH-1:0] q_s;

   assign q_s    = q;
   assign busy   = (rem != '0);
   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

   always_comb begin
      q_nxt     = q;
      rem_nxt   = rem;
      dir_nxt   = dir_lat;
      done_nxt  = 1'b0;
      burst_cnt = sat_count(count);
      if (busy) begin
         q_nxt    = dir_lat ? {q[WIDTH-2:0], serial_in} : {serial_in, q[WIDTH-1:1]};
         rem_nxt  = rem - CNT_W'(1);
         done_nxt = (rem == CNT_W'(1));
      end else if (en) begin
         case (sel)
            3'b001:  q_nxt = {serial_in, q[WIDTH-1:1]};
            3'b010:  q_nxt = {q[WIDTH-2:0], serial_in};
            3'b011:  q_nxt = parallel_in;
            3'b100:  q_nxt = {q[0], q[WIDTH-1:1]};
            3'b101:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b110:  q_nxt = q_s >>> 1;
            3'b111: begin
               // Start edge only latches the job; a zero-length burst completes immediately.
               rem_nxt  = burst_cnt;
               dir_nxt  = dir;
               done_nxt = (burst_cnt == '0);
            end
            default: q_nxt = q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= '0;
         rem     <= '0;
         dir_lat <= 1'b0;
         done    <= 1'b0;
      end else begin
         q       <= q_nxt;
         rem     <= rem_nxt;
         dir_lat <= dir_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_universal_shift_reg_burst.sv
// Directed scoreboard bench for universal_shift_reg_burst at WIDTH=8.
module tb_universal_shift_reg_burst;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [2:0]       sel;
   logic             serial_in;
   logic [WIDTH-1:0] parallel_in;
   logic [CNT_W-1:0] count;
   logic             dir;
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic             busy;
   logic             done;

   typedef struct {
      string            tag;
      logic [WIDTH-1:0] q;
      logic             busy;
      logic             done;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   universal_shift_reg_burst #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .en(en), .sel(sel), .serial_in(serial_in),
      .parallel_in(parallel_in), .count(count), .dir(dir), .q(q),
      .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic e, input logic [2:0] s, input logic si,
                        input logic [WIDTH-1:0] pi, input logic [CNT_W-1:0] c, input logic d);
      en = e; sel = s; serial_in = si; parallel_in = pi; count = c; dir = d;
   endtask

   // Push the expectation for the coming edge, clock it, then pop and compare mid-cycle.
   task automatic step(input string tag, input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
      exp_t e;
      exp_t p;
      e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      p = sb.pop_front();
      chk({p.tag, ".q"},      32'(q),      32'(p.q));
      chk({p.tag, ".busy"},   32'(busy),   32'(p.busy));
      chk({p.tag, ".done"},   32'(done),   32'(p.done));
      chk({p.tag, ".sout_r"}, 32'(sout_r), 32'(p.q[0]));
      chk({p.tag, ".sout_l"}, 32'(sout_l), 32'(p.q[WIDTH-1]));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]       sw_sel [6];
      logic [WIDTH-1:0] sw_exp [6];
      logic [WIDTH-1:0] eq;
      sw_sel = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
      sw_exp = '{8'h96, 8'hCB, 8'h2D, 8'h4B, 8'h2D, 8'hCB};

      // Reset state
      rst = 1'b1;
      drive(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
      step("reset", 8'h00, 1'b0, 1'b0);
      rst = 1'b0;

      // Reset in the middle of a 5-shift burst
      drive(1'b1, 3'b011, 1'b0, 8'h3C, '0, 1'b0);
      step("t1_load", 8'h3C, 1'b0, 1'b0);
      drive(1'b1, 3'b111, 1'b0, 8'h00, 4'd5, 1'b0);
      step("t1_e0", 8'h3C, 1'b1, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 8'h00, '0, 1'b0);
      step("t1_e1", 8'h1E, 1'b1, 1'b0);
      step("t1_e2", 8'h0F, 1'b1, 1'b0);
      rst = 1'b1;
      step("t1_rst", 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b1, 3'b011, 1'b0, 8'h5A, '0, 1'b0);
      step("t1_reload", 8'h5A, 1'b0, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 8'h00, '0, 1'b0);
      step("t1_idle", 8'h5A, 1'b0, 1'b0);

      // Single-cycle mode sweep from 1001_0110 with serial_in=1
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 3'b011, 1'b1, 8'h96, '0, 1'b0);
         step("t2_load", 8'h96, 1'b0, 1'b0);
         drive(1'b1, sw_sel[i], 1'b1, 8'h00, '0, 1'b0);
         step($sformatf("t2_mode%0d", sw_sel[i]), sw_exp[i], 1'b0, 1'b0);
      end
      drive(1'b0, 3'b011, 1'b1, 8'h00, '0, 1'b0);
      step("t2_en0_hold", 8'hCB, 1'b0, 1'b0);

      // Burst right by 3 from A5 with zero fill
      drive(1'b1, 3'b011, 1'b0, 8'hA5, '0, 1'b0);
      step("t3_load", 8'hA5, 1'b0, 1'b0);
      drive(1'b1, 3'b111, 1'b0, 8'h00, 4'd3, 1'b0);
      step("t3_e0", 8'hA5, 1'b1, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 8'h00, '0, 1'b0);
      step("t3_e1", 8'h52, 1'b1, 1'b0);
      step("t3_e2", 8'h29, 1'b1, 1'b0);
      step("t3_e3", 8'h14, 1'b0, 1'b1);
      step("t3_after", 8'h14, 1'b0, 1'b0);

      // Burst left with count=12 saturating to 8, one fill
      drive(1'b1, 3'b011, 1'b1, 8'h81, '0, 1'b0);
      step("t4_load", 8'h81, 1'b0, 1'b0);
      drive(1'b1, 3'b111, 1'b1, 8'h00, 4'd12, 1'b1);
      step("t4_e0", 8'h81, 1'b1, 1'b0);
      drive(1'b0, 3'b000, 1'b1, 8'h00, '0, 1'b0);
      eq = 8'h81;
      for (int k = 1; k <= 8; k++) begin
         eq = {eq[WIDTH-2:0], 1'b1};
         step($sformatf("t4_e%0d", k), eq, (k < 8), (k == 8));
      end
      step("t4_after", 8'hFF, 1'b0, 1'b0);

      // Zero-length burst
      drive(1'b1, 3'b111, 1'b0, 8'h00, 4'd0, 1'b0);
      step("t5_e0", 8'hFF, 1'b0, 1'b1);
      drive(1'b0, 3'b000, 1'b0, 8'h00, '0, 1'b0);
      step("t5_after", 8'hFF, 1'b0, 1'b0);

      // Commands issued while busy are dropped; the same command lands once idle
      drive(1'b1, 3'b011, 1'b0, 8'hA5, '0, 1'b0);
      step("t6_load", 8'hA5, 1'b0, 1'b0);
      drive(1'b1, 3'b111, 1'b0, 8'h00, 4'd3, 1'b0);
      step("t6_e0", 8'hA5, 1'b1, 1'b0);
      drive(1'b1, 3'b011, 1'b0, 8'h00, 4'd7, 1'b1);
      step("t6_e1", 8'h52, 1'b1, 1'b0);
      step("t6_e2", 8'h29, 1'b1, 1'b0);
      step("t6_e3", 8'h14, 1'b0, 1'b1);
      step("t6_load0", 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
